// File: rtl/alu_pkg.sv
// Shared opcode values, FSM state type and op classification for the multi-cycle ALU.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_XOR   = 4'd3;
    localparam logic [3:0] OP_SLL   = 4'd4;
    localparam logic [3:0] OP_SRL   = 4'd5;
    localparam logic [3:0] OP_SUB   = 4'd6;
    localparam logic [3:0] OP_SLT   = 4'd7;
    localparam logic [3:0] OP_ROTL  = 4'd8;
    localparam logic [3:0] OP_ROTR  = 4'd9;
    localparam logic [3:0] OP_SRA   = 4'd10;
    localparam logic [3:0] OP_SLTU  = 4'd11;
    localparam logic [3:0] OP_NOR   = 4'd12;
    localparam logic [3:0] OP_MULTU = 4'd13;
    localparam logic [3:0] OP_DIVU  = 4'd14;
    localparam logic [3:0] OP_MULT  = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ONE,
        ST_ITER,
        ST_DONE
    } state_t;

    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == OP_MULTU) || (op == OP_DIVU) || (op == OP_MULT);
    endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative radix-2 engine: shift-add multiplier and restoring divider on one shared adder.
module alu_seq_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             go,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             fin
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] b_q;
    logic             mode_q;
    logic [CW-1:0]    cnt;
    logic             running;

    logic [WIDTH-1:0] cur_hi, cur_lo, cur_b;
    logic             cur_mode;
    logic [WIDTH:0]   x, y;
    logic             cin;
    logic [WIDTH+1:0] sum;
    logic [WIDTH-1:0] nxt_hi, nxt_lo;

    // The go edge already performs the first step on the raw operands,
    // so the last step lands one edge earlier and the caller can register at fin.
    always_comb begin
        cur_hi   = go ? '0   : hi;
        cur_lo   = go ? a    : lo;
        cur_b    = go ? b    : b_q;
        cur_mode = go ? mode : mode_q;
        if (cur_mode) begin
            x   = {cur_hi, cur_lo[WIDTH-1]};
            y   = ~{1'b0, cur_b};
            cin = 1'b1;
        end else begin
            x   = {1'b0, cur_hi};
            y   = cur_lo[0] ? {1'b0, cur_b} : '0;
            cin = 1'b0;
        end
        sum = {1'b0, x} + {1'b0, y} + {{(WIDTH+1){1'b0}}, cin};
        if (cur_mode) begin
            // carry out of x + ~b + 1 means no borrow: partial remainder >= divisor
            nxt_hi = sum[WIDTH+1] ? sum[WIDTH-1:0] : x[WIDTH-1:0];
            nxt_lo = {cur_lo[WIDTH-2:0], sum[WIDTH+1]};
        end else begin
            {nxt_hi, nxt_lo} = {sum[WIDTH:0], cur_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hi      <= '0;
            lo      <= '0;
            b_q     <= '0;
            mode_q  <= 1'b0;
            cnt     <= '0;
            running <= 1'b0;
            fin     <= 1'b0;
        end else if (go) begin
            hi      <= nxt_hi;
            lo      <= nxt_lo;
            b_q     <= b;
            mode_q  <= mode;
            cnt     <= CW'(WIDTH - 1);
            running <= 1'b1;
            fin     <= 1'b0;
        end else if (running) begin
            hi  <= nxt_hi;
            lo  <= nxt_lo;
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
                running <= 1'b0;
                fin     <= 1'b1;
            end
        end else begin
            fin <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// WIDTH-bit EX-stage ALU: single-cycle logic/shift/compare ops plus iterative mul/div,
// with registered results and a Start/Busy/Done handshake.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ALUResult,
    output logic [WIDTH-1:0] HiResult,
    output logic             Zero
);

    state_t state;
    logic   neg;

    logic [SHW-1:0]     shamt;
    logic [SHW:0]       inv;
    logic [WIDTH-1:0]   one_res;
    logic               accept, multi, go;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   eng_hi, eng_lo;
    logic               fin;
    logic [2*WIDTH-1:0] prod, prod_fix;

    always_comb begin
        shamt = B[SHW-1:0];
        inv   = (SHW+1)'(WIDTH) - {1'b0, shamt};
        case (ALUControl)
            OP_AND:  one_res = A & B;
            OP_OR:   one_res = A | B;
            OP_ADD:  one_res = A + B;
            OP_XOR:  one_res = A ^ B;
            OP_SLL:  one_res = A << shamt;
            OP_SRL:  one_res = A >> shamt;
            OP_SUB:  one_res = A - B;
            OP_SLT:  one_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            // shift by inv == WIDTH yields zero, so rotate by 0 returns A
            OP_ROTL: one_res = (A << shamt) | (A >> inv);
            OP_ROTR: one_res = (A >> shamt) | (A << inv);
            OP_SRA:  one_res = $unsigned($signed(A) >>> shamt);
            OP_SLTU: one_res = {{(WIDTH-1){1'b0}}, A < B};
            OP_NOR:  one_res = ~(A | B);
            default: one_res = '0;
        endcase
    end

    always_comb begin
        accept = Start && (state == ST_IDLE || state == ST_DONE);
        multi  = is_multicycle(ALUControl);
        go     = accept && multi;
        a_mag  = (ALUControl == OP_MULT && A[WIDTH-1]) ? -A : A;
        b_mag  = (ALUControl == OP_MULT && B[WIDTH-1]) ? -B : B;
        prod     = {eng_hi, eng_lo};
        prod_fix = neg ? -prod : prod;
    end

    alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .Clk   (Clk),
        .Reset (Reset),
        .go    (go),
        .mode  (ALUControl == OP_DIVU),
        .a     (a_mag),
        .b     (b_mag),
        .hi    (eng_hi),
        .lo    (eng_lo),
        .fin   (fin)
    );

    // Single-cycle ops register their result on the accept edge itself, so
    // ONE never persists as a visible state; they go straight to DONE.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= ST_IDLE;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            ALUResult <= '0;
            HiResult  <= '0;
            Zero      <= 1'b1;
            neg       <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept && multi) begin
                        state <= ST_ITER;
                        Busy  <= 1'b1;
                        neg   <= (ALUControl == OP_MULT) && (A[WIDTH-1] ^ B[WIDTH-1]);
                    end else if (accept) begin
                        state     <= ST_DONE;
                        Done      <= 1'b1;
                        ALUResult <= one_res;
                        HiResult  <= '0;
                        Zero      <= (one_res == '0);
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_ITER: begin
                    if (fin) begin
                        state     <= ST_DONE;
                        Busy      <= 1'b0;
                        Done      <= 1'b1;
                        ALUResult <= prod_fix[WIDTH-1:0];
                        HiResult  <= prod_fix[2*WIDTH-1:WIDTH];
                        Zero      <= (prod_fix[WIDTH-1:0] == '0);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed corner cases plus randomized ops
// against an arithmetic reference model.
module tb_alu_multicycle;
    import alu_pkg::*;

    localparam int W = 32;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Start;
    logic [3:0]    ALUControl;
    logic [W-1:0]  A, B;
    logic          Busy, Done, Zero;
    logic [W-1:0]  ALUResult, HiResult;

    int checks   = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    alu_multicycle #(.WIDTH(W)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .ALUControl (ALUControl),
        .A          (A),
        .B          (B),
        .Busy       (Busy),
        .Done       (Done),
        .ALUResult  (ALUResult),
        .HiResult   (HiResult),
        .Zero       (Zero)
    );

    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        logic [31:0] r;
        longint      sp;
        sh = b % 32;
        r  = '0;
        case (op)
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_ADD:   r = a + b;
            OP_XOR:   r = a ^ b;
            OP_SLL:   r = a << sh;
            OP_SRL:   r = a >> sh;
            OP_SUB:   r = a - b;
            OP_SLT:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_ROTL:  r = (sh == 0) ? a : ((a << sh) | (a >> (32 - sh)));
            OP_ROTR:  r = (sh == 0) ? a : ((a >> sh) | (a << (32 - sh)));
            OP_SRA:   r = $unsigned($signed(a) >>> sh);
            OP_SLTU:  r = (a < b) ? 32'd1 : 32'd0;
            OP_NOR:   r = ~(a | b);
            OP_MULTU: return {32'd0, a} * {32'd0, b};
            OP_DIVU:  return (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            OP_MULT: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                return sp;
            end
            default:  r = '0;
        endcase
        return {32'd0, r};
    endfunction

    // Issue one op from a negedge and wait (bounded) for Done; returns at the Done negedge.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int poke_at,
                          output logic [31:0] lo, output logic [31:0] hi, output logic z,
                          output int lat, output bit busy_ok, output bit hold_ok);
        logic [31:0] prev_lo, prev_hi;
        bit          mc;
        prev_lo = ALUResult;
        prev_hi = HiResult;
        mc      = is_multicycle(op);
        Start = 1'b1; ALUControl = op; A = a; B = b;
        @(posedge Clk);
        lat = 0; busy_ok = 1'b1; hold_ok = 1'b1;
        while (lat < 100) begin
            @(negedge Clk);
            lat++;
            Start = (lat == poke_at);
            ALUControl = (lat == poke_at) ? OP_ADD : op;
            A = $urandom;
            B = $urandom;
            if (Done) break;
            if (Busy !== mc) busy_ok = 1'b0;
            if (ALUResult !== prev_lo || HiResult !== prev_hi) hold_ok = 1'b0;
        end
        if (Busy !== 1'b0) busy_ok = 1'b0;
        Start = 1'b0;
        lo = ALUResult;
        hi = HiResult;
        z  = Zero;
    endtask

    task automatic test_reset;
        Reset = 1'b1; Start = 1'b0; ALUControl = '0; A = '0; B = '0;
        repeat (2) @(negedge Clk);
        checks++;
        if ({Busy, Done, ALUResult, HiResult, Zero} !== {1'b0, 1'b0, 32'd0, 32'd0, 1'b1}) begin
            failures++;
            $display("FAIL reset_state: busy=%b done=%b lo=%h hi=%h zero=%b, want 0 0 0 0 1",
                     Busy, Done, ALUResult, HiResult, Zero);
        end
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_add_wrap;
        logic [31:0] lo, hi; logic z; int lat; bit bok, hok;
        run_op(OP_ADD, 32'hFFFFFFFF, 32'd1, 0, lo, hi, z, lat, bok, hok);
        checks++;
        if (lat !== 1 || lo !== 32'd0 || z !== 1'b1 || !bok) begin
            failures++;
            $display("FAIL add_wrap: lat=%0d lo=%h zero=%b busy_ok=%0d, want 1 0 1 1", lat, lo, z, bok);
        end
    endtask

    task automatic test_rotate;
        logic [31:0] lo, hi; logic z; int lat; bit bok, hok;
        run_op(OP_ROTL, 32'h80000001, 32'h21, 0, lo, hi, z, lat, bok, hok);
        checks++;
        if (lo !== 32'h00000003 || hi !== 32'd0) begin
            failures++;
            $display("FAIL rotl: lo=%h hi=%h, want 00000003 0", lo, hi);
        end
        run_op(OP_ROTR, 32'h80000001, 32'h21, 0, lo, hi, z, lat, bok, hok);
        checks++;
        if (lo !== 32'hC0000000 || hi !== 32'd0) begin
            failures++;
            $display("FAIL rotr: lo=%h hi=%h, want c0000000 0", lo, hi);
        end
        run_op(OP_ROTL, 32'h12345678, 32'h40, 0, lo, hi, z, lat, bok, hok);
        checks++;
        if (lo !== 32'h12345678) begin
            failures++;
            $display("FAIL rotl_zero: lo=%h, want 12345678", lo);
        end
    endtask

    task automatic test_mult;
        logic [31:0] lo, hi; logic z; int lat; bit bok, hok;
        run_op(OP_MULT, -32'sd3, 32'd7, 5, lo, hi, z, lat, bok, hok);
        checks++;
        if (lat !== W + 1) begin
            failures++;
            $display("FAIL mult_latency: got %0d cycles, want %0d", lat, W + 1);
        end
        checks++;
        if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB || z !== 1'b0) begin
            failures++;
            $display("FAIL mult_value: got %h zero=%b, want ffffffffffffffeb 0", {hi, lo}, z);
        end
        checks++;
        if (!bok || !hok) begin
            failures++;
            $display("FAIL mult_busy_hold: busy_ok=%0d hold_ok=%0d, want 1 1", bok, hok);
        end
        @(negedge Clk);
        checks++;
        if (Done !== 1'b0) begin
            failures++;
            $display("FAIL mult_done_pulse: done=%b after pulse, want 0", Done);
        end
    endtask

    task automatic test_divu;
        logic [31:0] lo, hi; logic z; int lat; bit bok, hok;
        run_op(OP_DIVU, 32'd100, 32'd7, 0, lo, hi, z, lat, bok, hok);
        checks++;
        if (lo !== 32'd14 || hi !== 32'd2 || lat !== W + 1) begin
            failures++;
            $display("FAIL divu: q=%0d r=%0d lat=%0d, want 14 2 %0d", lo, hi, lat, W + 1);
        end
        run_op(OP_DIVU, 32'd5, 32'd0, 0, lo, hi, z, lat, bok, hok);
        checks++;
        if (lo !== 32'hFFFFFFFF || hi !== 32'd5 || lat !== W + 1) begin
            failures++;
            $display("FAIL divu_by_zero: q=%h r=%0d lat=%0d, want ffffffff 5 %0d", lo, hi, lat, W + 1);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        Start = 1'b1; ALUControl = OP_MULTU; A = 32'd6; B = 32'd7;
        @(posedge Clk);
        n = 0;
        // Start stays high with SLT operands through the whole busy window
        do begin
            @(negedge Clk);
            n++;
            ALUControl = OP_SLT; A = 32'hFFFFFFFF; B = 32'd0;
        end while (!Done && n < 100);
        checks++;
        if (Done !== 1'b1 || ALUResult !== 32'd42 || HiResult !== 32'd0 || n !== W + 1) begin
            failures++;
            $display("FAIL b2b_multu: done=%b lo=%0d hi=%0d lat=%0d, want 1 42 0 %0d",
                     Done, ALUResult, HiResult, n, W + 1);
        end
        @(negedge Clk);
        Start = 1'b0;
        checks++;
        if (Done !== 1'b1 || Busy !== 1'b0 || ALUResult !== 32'd1 || HiResult !== 32'd0 || Zero !== 1'b0) begin
            failures++;
            $display("FAIL b2b_slt: done=%b busy=%b lo=%0d hi=%0d zero=%b, want 1 0 1 0 0",
                     Done, Busy, ALUResult, HiResult, Zero);
        end
        @(negedge Clk);
    endtask

    task automatic test_random;
        logic [31:0] lo, hi, a, b; logic z; int lat; bit bok, hok;
        logic [3:0] op;
        logic [63:0] exp;
        int exp_lat;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: begin a = $urandom_range(0, 300); b = $urandom_range(0, 20); end
                1: begin a = 32'hFFFFFFFF - $urandom_range(0, 5); b = $urandom; end
                default: begin a = $urandom; b = $urandom; end
            endcase
            exp     = model(op, a, b);
            exp_lat = is_multicycle(op) ? W + 1 : 1;
            run_op(op, a, b, (i % 3 == 0) ? 3 : 0, lo, hi, z, lat, bok, hok);
            checks++;
            if ({hi, lo} !== exp || z !== (exp[31:0] == 32'd0)) begin
                failures++;
                $display("FAIL rand_result op=%0d a=%h b=%h: got %h zero=%b, want %h", op, a, b,
                         {hi, lo}, z, exp);
            end
            checks++;
            if (lat !== exp_lat || !bok || !hok) begin
                failures++;
                $display("FAIL rand_timing op=%0d: lat=%0d busy_ok=%0d hold_ok=%0d, want %0d 1 1",
                         op, lat, bok, hok, exp_lat);
            end
        end
    endtask

    task automatic test_reset_mid_mult;
        logic [31:0] lo, hi; logic z; int lat; bit bok, hok;
        bit saw_done;
        run_op(OP_ADD, 32'd5, 32'd5, 0, lo, hi, z, lat, bok, hok);
        Start = 1'b1; ALUControl = OP_MULT; A = 32'd1234; B = 32'd5678;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        repeat (9) @(negedge Clk);
        Reset = 1'b1;
        #1;
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || ALUResult !== 32'd0 || Zero !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_mult: busy=%b done=%b lo=%h zero=%b, want 0 0 0 1",
                     Busy, Done, ALUResult, Zero);
        end
        @(negedge Clk);
        Reset = 1'b0;
        saw_done = 1'b0;
        repeat (W + 8) begin
            @(negedge Clk);
            if (Done || Busy) saw_done = 1'b1;
        end
        checks++;
        if (saw_done || ALUResult !== 32'd0 || Zero !== 1'b1) begin
            failures++;
            $display("FAIL reset_abort: activity=%0d lo=%h zero=%b, want 0 0 1", saw_done, ALUResult, Zero);
        end
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_rotate();
        test_mult();
        test_divu();
        test_back_to_back();
        test_random();
        test_reset_mid_mult();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
